logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Round-robin arbiter that shares one 2-input programmable logic evaluator among N requesters.
- Each requester presents operands a, b and a 4-bit truth-table code func; the evaluated result is func[{a,b}], i.e. func bit index 2*a+b.
- Sits between requesting sequencers and any downstream consumer.
- Provides a registered result stage with a valid/ready handshake, tagged with the requester index, plus a saturating completed-operation counter.

Parameters:
- N, 4, number of requesters (2..8).
- TAG_W, 2, width of result tag. Must satisfy N <= 2**TAG_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request. Held high with stable operands until granted.
- a  in  N  operand a, bit i belongs to requester i.
- b  in  N  operand b, bit i belongs to requester i.
- func  in  4*N  truth-table codes. Requester i uses func[4i+3:4i].
- gnt  out  N  one-hot or zero combinational grant. Request i is accepted at the edge where req[i] && gnt[i].
- res_valid  out  1  result register holds an unconsumed result.
- res_out  out  1  evaluated result.
- res_tag  out  TAG_W  index of the requester that produced res_out.
- res_ready  in  1  downstream accepts the result at the edge where res_valid && res_ready.
- busy  out  1  high when res_valid=1 or any req bit is high.
- op_count  out  16  count of consumed results. Saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at edge):
  - res_valid=0, res_out=0, res_tag=0, op_count=0.
  - Round-robin pointer last=N-1, so requester 0 has highest priority first.
  - gnt is 0 during the reset cycle.
- Issue condition: can_issue = !res_valid || res_ready. This gives a bypassing output stage and a throughput of one op per cycle.
- Grant: if can_issue and req!=0, gnt selects the first set req bit searching upward from last+1, wrapping modulo N. Otherwise gnt=0.
  - gnt depends only on req, last, res_valid, res_ready and rst. It does not depend on a, b or func.
- Accept edge (some gnt[i]=1):
  - res_out <= func[4i + 2*a[i] + b[i]]
  - res_tag <= i
  - res_valid <= 1
  - last <= i
- Latency: result visible exactly one cycle after the accept edge.
- Consume edge (res_valid && res_ready):
  - op_count increments unless it is already 16'hFFFF.
  - If no accept occurs at the same edge, res_valid <= 0.
- Simultaneous consume + accept: the new result replaces the old one. res_valid stays 1, op_count increments once.
- Stall (res_valid=1, res_ready=0):
  - gnt=0.
  - The result register and last hold their values.
  - Requesters keep req asserted.
- Fairness: with all req high and res_ready=1, grants rotate 0,1,2,...,N-1,0... One grant per cycle, no requester skipped.
- A requester that drops req before being granted is simply skipped. No state is retained for it.
- Reset mid-operation: a pending unconsumed result is discarded without being counted. Arbitration restarts from requester 0.
- No combinational path from res_ready to res_valid, res_out or res_tag.

Test Plan:
- Reset, then req=4'b0001, a[0]=0, b[0]=1, func[3:0]=4'b0010, res_ready=1 → gnt=4'b0001 in that cycle. Next cycle res_valid=1, res_out=1, res_tag=0. op_count=1 after the consume edge.
- All four func codes held at 4'b1000 (AND), all a=b=1, req=4'hF, res_ready=1 for 8 cycles → gnt sequence 1,2,4,8,1,2,4,8. res_tag sequence 0,1,2,3,0,1,2,3 with res_out=1 every cycle. op_count=8.
- res_valid=1 holding tag 2, res_ready=0 for 3 cycles with req=4'hF → gnt=0 and outputs frozen. On res_ready=1, tag 2 consumed and tag 3 granted in the same cycle.
- Exhaustive evaluation for requester 1: all 16 func codes × 4 (a,b) pairs → res_out equals func bit (2a+b) for all 64 cases.
- Reset asserted while res_valid=1 and req=4'hF → next cycle res_valid=0, op_count=0, gnt=0 during reset. First grant after reset goes to requester 0.
- Preload op_count near saturation (65540 consumes) → op_count stops at 16'hFFFF and never wraps to 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 2-input programmable logic evaluator.
// Registered, tagged result with valid/ready and a saturating op counter.
module logic_unit_arbiter #(
  parameter int N     = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [4*N-1:0]   func,
  output logic [N-1:0]     gnt,
  output logic             res_valid,
  output logic             res_out,
  output logic [TAG_W-1:0] res_tag,
  input  logic             res_ready,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int M = 2 ** TAG_W;

  logic [TAG_W-1:0] r_last;
  logic             r_valid;
  logic             r_out;
  logic [TAG_W-1:0] r_tag;
  logic [15:0]      r_cnt;

  logic [M-1:0]     w_r;
  logic [M-1:0]     w_a;
  logic [M-1:0]     w_b;
  logic [3:0]       w_fn [M];
  logic [M-1:0]     w_g;
  logic             w_hit;
  logic [TAG_W-1:0] w_idx;
  logic             w_bit;
  logic             w_can;
  logic             w_cons;

  // Widen per-requester inputs to the full tag space so indexing stays in range
  for (genvar g = 0; g < M; g++) begin : g_pad
    if (g < N) begin : g_real
      assign w_r[g]  = req[g];
      assign w_a[g]  = a[g];
      assign w_b[g]  = b[g];
      assign w_fn[g] = func[4*g +: 4];
    end else begin : g_zero
      assign w_r[g]  = 1'b0;
      assign w_a[g]  = 1'b0;
      assign w_b[g]  = 1'b0;
      assign w_fn[g] = 4'b0;
    end
  end

  // Round-robin search upward from last+1 and evaluate the winner's truth table
  always_comb begin
    logic [TAG_W:0]   s;
    logic [TAG_W-1:0] idx;
    w_g   = '0;
    w_hit = 1'b0;
    w_idx = '0;
    w_bit = 1'b0;
    s     = '0;
    idx   = '0;
    w_can = !r_valid || res_ready;
    if (!rst && w_can) begin
      for (int k = 1; k <= N; k++) begin
        s = {1'b0, r_last} + (TAG_W+1)'(k);
        if (s >= (TAG_W+1)'(N)) s = s - (TAG_W+1)'(N);
        idx = s[TAG_W-1:0];
        if (!w_hit && w_r[idx]) begin
          w_hit = 1'b1;
          w_idx = idx;
        end
      end
    end
    if (w_hit) begin
      w_g[w_idx] = 1'b1;
      w_bit      = w_fn[w_idx][{w_a[w_idx], w_b[w_idx]}];
    end
  end

  assign w_cons    = r_valid && res_ready;
  assign gnt       = w_g[N-1:0];
  assign res_valid = r_valid;
  assign res_out   = r_out;
  assign res_tag   = r_tag;
  assign op_count  = r_cnt;
  assign busy      = r_valid || (|req);

  // Result stage, round-robin pointer and saturating consume counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_out   <= 1'b0;
      r_tag   <= '0;
      r_cnt   <= '0;
      r_last  <= TAG_W'(N - 1);
    end else begin
      if (w_cons && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      if (w_hit) begin
        r_out   <= w_bit;
        r_tag   <= w_idx;
        r_valid <= 1'b1;
        r_last  <= w_idx;
      end else if (w_cons) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed plus randomized bench for logic_unit_arbiter.
// Expected values come from a behavioural model of the arbitration rules.
module tb_logic_unit_arbiter;

  localparam int N     = 4;
  localparam int TAG_W = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [4*N-1:0]   func;
  logic [N-1:0]     gnt;
  logic             res_valid;
  logic             res_out;
  logic [TAG_W-1:0] res_tag;
  logic             res_ready;
  logic             busy;
  logic [15:0]      op_count;

  int passed = 0;
  int total  = 0;

  bit m_valid;
  bit m_out;
  int m_tag;
  int m_last;
  int m_cnt;

  logic_unit_arbiter #(.N(N), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .func(func),
    .gnt(gnt), .res_valid(res_valid), .res_out(res_out),
    .res_tag(res_tag), .res_ready(res_ready), .busy(busy),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bit_of(input logic [31:0] v, input int i);
    return ((v >> i) & 32'd1) != 32'd0;
  endfunction

  // Winner = requesting index at the smallest circular distance after last
  function automatic int exp_grant();
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    if (rst || (m_valid && !res_ready) || req == '0) return -1;
    for (int i = 0; i < N; i++) begin
      if (bit_of(32'(req), i)) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", t, o, e);
  endtask

  task automatic step(input bit r, input logic [N-1:0] q,
                      input logic [N-1:0] aa, input logic [N-1:0] bb,
                      input logic [4*N-1:0] ff, input bit rdy);
    int g;
    int sel;
    bit cons;
    logic [N-1:0] eg;
    rst       = r;
    req       = q;
    a         = aa;
    b         = bb;
    func      = ff;
    res_ready = rdy;
    #3;
    g  = exp_grant();
    eg = '0;
    if (g >= 0) eg = N'(1) << g;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    if (m_valid) begin
      chk("res_out", 32'(res_out), 32'(m_out));
      chk("res_tag", 32'(res_tag), 32'(m_tag));
    end
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_valid || (q != '0)));
    @(posedge clk);
    if (r) begin
      m_valid = 0;
      m_out   = 0;
      m_tag   = 0;
      m_cnt   = 0;
      m_last  = N - 1;
    end else begin
      cons = m_valid && rdy;
      if (cons && m_cnt < 65535) m_cnt++;
      if (g >= 0) begin
        sel     = 4 * g + 2 * int'(bit_of(32'(aa), g)) + int'(bit_of(32'(bb), g));
        m_out   = bit_of(32'(ff), sel);
        m_tag   = g;
        m_valid = 1;
        m_last  = g;
      end else if (cons) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    rst = 1'b1; req = '0; a = '0; b = '0; func = '0; res_ready = 1'b0;
    m_valid = 0; m_out = 0; m_tag = 0; m_last = N - 1; m_cnt = 0;
    @(posedge clk);
    #1;

    step(1, '0, '0, '0, '0, 1);
    step(0, 4'b0001, 4'b0000, 4'b0001, 16'h0002, 1);
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_out", 32'(res_out), 32'd1);
    chk("t1_tag", 32'(res_tag), 32'd0);
    step(0, '0, '0, '0, '0, 1);
    chk("t1_cnt", 32'(op_count), 32'd1);

    step(1, '0, '0, '0, '0, 1);
    for (int i = 0; i < 8; i++) step(0, 4'hF, 4'hF, 4'hF, 16'h8888, 1);
    step(0, '0, '0, '0, '0, 1);
    chk("t2_cnt", 32'(op_count), 32'd8);

    step(0, 4'b0100, 4'h0, 4'h0, 16'h0F00, 1);
    for (int i = 0; i < 3; i++) step(0, 4'hF, 4'h3, 4'h5, 16'h8421, 0);
    chk("t3_hold_tag", 32'(res_tag), 32'd2);
    req = 4'hF; res_ready = 1'b1;
    #2;
    chk("t3_gnt3", 32'(gnt), 32'h8);
    #1;
    step(0, 4'hF, 4'h3, 4'h5, 16'h8421, 1);
    chk("t3_tag3", 32'(res_tag), 32'd3);

    for (int f = 0; f < 16; f++) begin
      for (int ab = 0; ab < 4; ab++) begin
        step(0, 4'b0010, N'((ab >> 1) & 1) << 1, N'(ab & 1) << 1,
             (16'(f) << 4) | 16'($urandom & 32'hF00F), 1);
      end
    end
    step(0, '0, '0, '0, '0, 1);

    for (int i = 0; i < 300; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      step(0, N'($urandom), ra, rb, 16'($urandom), $urandom_range(0, 9) < 7);
    end

    step(0, 4'hF, 4'hF, 4'h0, 16'hAAAA, 0);
    step(0, 4'hF, 4'hF, 4'h0, 16'hAAAA, 0);
    step(1, 4'hF, 4'hF, 4'h0, 16'hAAAA, 1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_cnt", 32'(op_count), 32'd0);
    step(0, 4'hF, 4'hF, 4'h0, 16'hAAAA, 1);
    chk("rst_first_tag", 32'(res_tag), 32'd0);

    step(1, '0, '0, '0, '0, 1);
    for (int i = 0; i < 65545; i++) step(0, 4'b0001, 4'h1, 4'h1, 16'h0008, 1);
    step(0, '0, '0, '0, '0, 1);
    chk("sat_cnt", 32'(op_count), 32'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
